// File: rtl/cpu_branch_unit.sv
// Execute-stage branch resolver for RV32I conditional branches, JAL and JALR.
// It drives the compare ALU's signedness select and uses the ALU's eq/lt
// results to decide taken/not-taken. It computes the redirect target and the
// link value (pc+4). The result goes into a one-entry valid/ready output stage
// that feeds writeback.
//
// Ports:
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   in_valid_i/in_ready_o  upstream handshake
//   op_i                   0=none, 1=cond branch, 2=JAL, 3=JALR
//   funct3_i               branch condition encoding
//   pc_i, imm_i, rs1_i     operands for target and link arithmetic
//   compare_unsigned_o     to ALU: unsigned compare select (combinational)
//   compare_eq_i/_lt_i     from ALU: compare results
//   flush_i                kill held result, block acceptance
//   out_valid_o/ready_i    downstream handshake
//   taken_o, link_o        registered result
//   redirect_o             one-cycle fetch redirect pulse
//   redirect_pc_o          redirect target
//   misaligned_o           taken target with bit1 set (redirect suppressed)
//   illegal_o              conditional branch with funct3 010/011
module cpu_branch_unit #(
  parameter logic [31:0] RESET_PC_LINK = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic        compare_unsigned_o,
  input  logic        compare_eq_i,
  input  logic        compare_lt_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        taken_o,
  output logic [31:0] link_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_BRANCH = 2'd1;
  localparam logic [1:0] OP_JAL    = 2'd2;
  localparam logic [1:0] OP_JALR   = 2'd3;

  logic            accept;
  logic            cond_taken;
  logic            cond_illegal;
  logic            raw_taken;
  logic            dec_illegal;
  logic            dec_misaligned;
  logic            final_taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;

  // funct3[1] selects unsigned compare (BLTU/BGEU); it does not depend on op or valid
  assign compare_unsigned_o = funct3_i[1];

  assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Conditional branch decode from the ALU compare results
  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (funct3_i)
      3'b000:          cond_taken = compare_eq_i;
      3'b001:          cond_taken = !compare_eq_i;
      3'b100, 3'b110:  cond_taken = compare_lt_i;
      3'b101, 3'b111:  cond_taken = !compare_lt_i;
      default:         cond_illegal = 1'b1;
    endcase
  end

  // Op decode, target and link arithmetic (mod 2^32)
  always_comb begin
    raw_taken   = 1'b0;
    dec_illegal = 1'b0;
    target      = pc_i + imm_i;
    link        = pc_i + XLEN'(4);
    case (op_i)
      OP_NONE: raw_taken = 1'b0;
      OP_BRANCH: begin
        raw_taken   = cond_taken;
        dec_illegal = cond_illegal;
      end
      OP_JAL:  raw_taken = 1'b1;
      OP_JALR: begin
        raw_taken = 1'b1;
        target    = (rs1_i + imm_i) & ~XLEN'(1);
      end
      default: raw_taken = 1'b0;
    endcase
  end

  // A taken transfer to a halfword-only aligned target becomes an exception.
  // Target bit1 on a not-taken branch does not matter.
  assign dec_misaligned = raw_taken && target[1];
  assign final_taken    = raw_taken && !target[1];

  // One-entry output stage. The redirect pulse fires only on the cycle after
  // an accept. A held result never re-asserts it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o   <= 1'b0;
      taken_o       <= 1'b0;
      link_o        <= RESET_PC_LINK;
      redirect_o    <= 1'b0;
      redirect_pc_o <= RESET_PC_LINK;
      misaligned_o  <= 1'b0;
      illegal_o     <= 1'b0;
    end else begin
      redirect_o <= accept && final_taken;
      if (flush_i) begin
        out_valid_o <= 1'b0;
      end else if (accept) begin
        out_valid_o   <= 1'b1;
        taken_o       <= final_taken;
        link_o        <= link;
        redirect_pc_o <= target;
        misaligned_o  <= dec_misaligned;
        illegal_o     <= dec_illegal;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_branch_unit.sv
// Directed bench for cpu_branch_unit: a vector table for decode/arithmetic
// plus hand-written sequences for reset, backpressure, back-to-back and flush.
module tb_cpu_branch_unit;

  localparam logic [31:0] RST_VAL = 32'hDEAD_BEE0;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  op_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic        compare_unsigned_o;
  logic        compare_eq_i;
  logic        compare_lt_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        taken_o;
  logic [31:0] link_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        misaligned_o;
  logic        illegal_o;

  int checks = 0;
  int failures = 0;

  cpu_branch_unit #(.RESET_PC_LINK(RST_VAL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .funct3_i(funct3_i), .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i),
    .compare_unsigned_o(compare_unsigned_o),
    .compare_eq_i(compare_eq_i), .compare_lt_i(compare_lt_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .taken_o(taken_o), .link_o(link_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .misaligned_o(misaligned_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        eq;
    logic        lt;
    logic        e_taken;
    logic [31:0] e_pc;
    logic [31:0] e_link;
    logic        e_mis;
    logic        e_ill;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic eq, input logic lt);
    op_i = op; funct3_i = f3; pc_i = pc; imm_i = imm; rs1_i = rs1;
    compare_eq_i = eq; compare_lt_i = lt;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name         op    f3      pc            imm           rs1          eq    lt    tk    target        link          mis   ill
    vecs[0]  = '{"beq_t",     2'd1, 3'b000, 32'h100,      32'h20,       32'h0,       1'b1, 1'b0, 1'b1, 32'h120,      32'h104,      1'b0, 1'b0};
    vecs[1]  = '{"beq_nt",    2'd1, 3'b000, 32'h100,      32'h20,       32'h0,       1'b0, 1'b1, 1'b0, 32'h120,      32'h104,      1'b0, 1'b0};
    vecs[2]  = '{"bne_t",     2'd1, 3'b001, 32'h100,      32'h20,       32'h0,       1'b0, 1'b0, 1'b1, 32'h120,      32'h104,      1'b0, 1'b0};
    vecs[3]  = '{"blt_t",     2'd1, 3'b100, 32'h200,      32'hFFFF_FFF8,32'h0,       1'b0, 1'b1, 1'b1, 32'h1F8,      32'h204,      1'b0, 1'b0};
    vecs[4]  = '{"bge_nt",    2'd1, 3'b101, 32'h200,      32'h40,       32'h0,       1'b0, 1'b1, 1'b0, 32'h240,      32'h204,      1'b0, 1'b0};
    vecs[5]  = '{"bltu_nt",   2'd1, 3'b110, 32'h200,      32'h40,       32'h0,       1'b1, 1'b0, 1'b0, 32'h240,      32'h204,      1'b0, 1'b0};
    vecs[6]  = '{"bgeu_nt",   2'd1, 3'b111, 32'h200,      32'h40,       32'h0,       1'b0, 1'b1, 1'b0, 32'h240,      32'h204,      1'b0, 1'b0};
    vecs[7]  = '{"ill_010",   2'd1, 3'b010, 32'h300,      32'h10,       32'h0,       1'b1, 1'b1, 1'b0, 32'h310,      32'h304,      1'b0, 1'b1};
    vecs[8]  = '{"ill_011",   2'd1, 3'b011, 32'h300,      32'h10,       32'h0,       1'b1, 1'b0, 1'b0, 32'h310,      32'h304,      1'b0, 1'b1};
    vecs[9]  = '{"jalr_al",   2'd3, 3'b000, 32'h400,      32'h4,        32'h1001,    1'b0, 1'b0, 1'b1, 32'h1004,     32'h404,      1'b0, 1'b0};
    vecs[10] = '{"jalr_mis",  2'd3, 3'b000, 32'h400,      32'h0,        32'h1002,    1'b0, 1'b0, 1'b0, 32'h1002,     32'h404,      1'b1, 1'b0};
    vecs[11] = '{"jal_wrap",  2'd2, 3'b000, 32'hFFFF_FFF0,32'h20,       32'h0,       1'b0, 1'b0, 1'b1, 32'h10,       32'hFFFF_FFF4,1'b0, 1'b0};
    vecs[12] = '{"op_none",   2'd0, 3'b000, 32'h500,      32'h8,        32'h0,       1'b1, 1'b0, 1'b0, 32'h508,      32'h504,      1'b0, 1'b0};
    vecs[13] = '{"beq_mis",   2'd1, 3'b000, 32'h100,      32'h2,        32'h0,       1'b1, 1'b0, 1'b0, 32'h102,      32'h104,      1'b1, 1'b0};
    vecs[14] = '{"bne_nt_b1", 2'd1, 3'b001, 32'h100,      32'h2,        32'h0,       1'b1, 1'b0, 1'b0, 32'h102,      32'h104,      1'b0, 1'b0};

    rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk("rst_out_valid", 32'(out_valid_o), 32'h0);
    chk("rst_taken", 32'(taken_o), 32'h0);
    chk("rst_redirect", 32'(redirect_o), 32'h0);
    chk("rst_mis", 32'(misaligned_o), 32'h0);
    chk("rst_ill", 32'(illegal_o), 32'h0);
    chk("rst_link", link_o, RST_VAL);
    chk("rst_rpc", redirect_pc_o, RST_VAL);
    rst_i = 1'b0;
    tick();

    // Table-driven decode/arithmetic, one instruction at a time with drain
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].eq, vecs[i].lt);
      in_valid_i = 1'b1;
      #1;
      chk({vecs[i].name, "_cmp_unsigned"}, 32'(compare_unsigned_o), 32'(vecs[i].f3[1]));
      chk({vecs[i].name, "_in_ready"}, 32'(in_ready_o), 32'h1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      chk({vecs[i].name, "_out_valid"}, 32'(out_valid_o), 32'h1);
      chk({vecs[i].name, "_taken"}, 32'(taken_o), 32'(vecs[i].e_taken));
      chk({vecs[i].name, "_redirect"}, 32'(redirect_o), 32'(vecs[i].e_taken));
      chk({vecs[i].name, "_rpc"}, redirect_pc_o, vecs[i].e_pc);
      chk({vecs[i].name, "_link"}, link_o, vecs[i].e_link);
      chk({vecs[i].name, "_mis"}, 32'(misaligned_o), 32'(vecs[i].e_mis));
      chk({vecs[i].name, "_ill"}, 32'(illegal_o), 32'(vecs[i].e_ill));
      tick();
      chk({vecs[i].name, "_drained"}, 32'(out_valid_o), 32'h0);
      chk({vecs[i].name, "_redirect_end"}, 32'(redirect_o), 32'h0);
    end

    // Backpressure: a taken result is held for 3 cycles while another input waits
    out_ready_i = 1'b0;
    drive(2'd1, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);
    in_valid_i = 1'b1;
    tick();
    drive(2'd2, 3'b000, 32'h40, 32'h100, 32'h0, 1'b0, 1'b0);
    chk("bp_redirect_first", 32'(redirect_o), 32'h1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready_o), 32'h0);
      chk("bp_out_valid", 32'(out_valid_o), 32'h1);
      chk("bp_rpc", redirect_pc_o, 32'h120);
      chk("bp_link", link_o, 32'h104);
      chk("bp_taken", 32'(taken_o), 32'h1);
      tick();
      chk("bp_redirect_held", 32'(redirect_o), 32'h0);
    end
    // Drain and accept in the same cycle: JAL 0x40+0x100
    out_ready_i = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready_o), 32'h1);
    tick();
    in_valid_i = 1'b0;
    chk("b2b_out_valid", 32'(out_valid_o), 32'h1);
    chk("b2b_rpc", redirect_pc_o, 32'h140);
    chk("b2b_link", link_o, 32'h44);
    chk("b2b_redirect", 32'(redirect_o), 32'h1);
    tick();
    chk("b2b_drained", 32'(out_valid_o), 32'h0);

    // Flush with a held result and a pending input
    out_ready_i = 1'b0;
    drive(2'd1, 3'b001, 32'h600, 32'h10, 32'h0, 1'b0, 1'b0);
    in_valid_i = 1'b1;
    tick();
    drive(2'd2, 3'b000, 32'h700, 32'h8, 32'h0, 1'b0, 1'b0);
    flush_i = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready_o), 32'h0);
    chk("fl_redirect_visible", 32'(redirect_o), 32'h1);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("fl_out_valid", 32'(out_valid_o), 32'h0);
    chk("fl_redirect", 32'(redirect_o), 32'h0);
    tick();
    chk("fl_not_consumed", 32'(out_valid_o), 32'h0);
    chk("fl_no_redirect", 32'(redirect_o), 32'h0);

    // Asynchronous reset mid-cycle while a result is held
    drive(2'd2, 3'b000, 32'h800, 32'h20, 32'h0, 1'b0, 1'b0);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("ar_pre_valid", 32'(out_valid_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid_o), 32'h0);
    chk("ar_redirect", 32'(redirect_o), 32'h0);
    chk("ar_link", link_o, RST_VAL);
    chk("ar_rpc", redirect_pc_o, RST_VAL);
    #2;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("ar_after_valid", 32'(out_valid_o), 32'h0);
      chk("ar_after_redirect", 32'(redirect_o), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
